// File: rtl/freq_divider_ctrl.sv
// Run-time controller for the counter-based clock divider.
// Owns the divide counter and divisor; reconfigures only on period boundaries.
module freq_divider_ctrl #(
   parameter int WIDTH       = 10,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_divisor,
   output logic             cfg_ready,
   output logic             cfg_error,
   output logic             clock_out,
   output logic             tick,
   output logic             active,
   output logic [WIDTH-1:0] cur_divisor
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cur_div_q, cur_div_d;
   logic [WIDTH-1:0] next_div_q, next_div_d;
   logic             pending_q, pending_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;

   logic act_s;
   logic wrap_s;
   logic xfer_s;
   logic legal_s;

   assign act_s   = (state_q != IDLE);
   assign wrap_s  = act_s && (cnt_q == cur_div_q - WIDTH'(1));
   assign xfer_s  = cfg_valid && !pending_q;
   assign legal_s = (cfg_divisor >= WIDTH'(2));

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_div_q  <= WIDTH'(DEFAULT_DIV);
         next_div_q <= WIDTH'(DEFAULT_DIV);
         pending_q  <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         next_div_q <= next_div_d;
         pending_q  <= pending_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
      end
   end

   // Disabling on the wrap edge ends the run there: no extra period.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (enable) state_d = RUN;
         RUN: begin
            if (!enable) state_d = wrap_s ? IDLE : STOP;
         end
         STOP: begin
            if (enable)      state_d = RUN;
            else if (wrap_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = (!act_s || wrap_s) ? '0 : cnt_q + WIDTH'(1);
      cur_div_d  = cur_div_q;
      next_div_d = next_div_q;
      pending_d  = pending_q;
      // A divisor left pending by a stop is applied once idle.
      if (pending_q && (wrap_s || !act_s)) begin
         cur_div_d = next_div_q;
         pending_d = 1'b0;
      end
      if (xfer_s && legal_s) begin
         if (!act_s) begin
            cur_div_d = cfg_divisor;
         end else begin
            next_div_d = cfg_divisor;
            pending_d  = 1'b1;
         end
      end
      err_d     = xfer_s && !legal_s;
      clk_out_d = act_s && (cnt_q < (cur_div_q >> 1));
      tick_d    = act_s && (cnt_q == '0);
   end

   always_comb begin
      active      = act_s;
      cfg_ready   = !pending_q;
      cfg_error   = err_q;
      clock_out   = clk_out_q;
      tick        = tick_q;
      cur_divisor = cur_div_q;
   end

endmodule

// File: tb/tb_freq_divider_ctrl.sv
// Bench for freq_divider_ctrl: directed plan plus random traffic,
// checked every cycle against a period-queue reference model.
module tb_freq_divider_ctrl;

   localparam int W   = 10;
   localparam int DEF = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         v;
   logic [W-1:0] dv;
   logic         rdy;
   logic         err;
   logic         cko;
   logic         tck;
   logic         act;
   logic [W-1:0] cdiv;

   int checks = 0;
   int errors = 0;

   // Model: one {tick,clk} entry per remaining cycle of the period.
   logic [1:0] m_q[$];
   bit         m_act;
   int         m_div;
   bit         m_pend;
   int         m_next;
   bit         e_clk;
   bit         e_tick;
   bit         e_err;

   freq_divider_ctrl #(
      .WIDTH(W),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clock_in(clk),
      .reset_n(rst_n),
      .enable(en),
      .cfg_valid(v),
      .cfg_divisor(dv),
      .cfg_ready(rdy),
      .cfg_error(err),
      .clock_out(cko),
      .tick(tck),
      .active(act),
      .cur_divisor(cdiv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic fill(input int d);
      for (int i = 0; i < d; i++)
         m_q.push_back({i == 0, i < d / 2});
   endtask

   task automatic model_edge();
      bit xfer;
      bit legal;
      logic [1:0] s;
      if (!rst_n) begin
         m_q.delete();
         m_act  = 0;
         m_div  = DEF;
         m_pend = 0;
         e_clk  = 0;
         e_tick = 0;
         e_err  = 0;
      end else begin
         xfer  = v && !m_pend;
         legal = (int'(dv) >= 2);
         e_err = xfer && !legal;
         if (m_act) begin
            s = m_q.pop_front();
            e_tick = s[1];
            e_clk  = s[0];
            if (m_q.size() == 0) begin
               if (m_pend) begin
                  m_div  = m_next;
                  m_pend = 0;
               end
               if (en) fill(m_div);
               else    m_act = 0;
            end
            if (xfer && legal) begin
               m_pend = 1;
               m_next = int'(dv);
            end
         end else begin
            e_clk  = 0;
            e_tick = 0;
            if (m_pend) begin
               m_div  = m_next;
               m_pend = 0;
            end
            if (xfer && legal) m_div = int'(dv);
            if (en) begin
               m_act = 1;
               fill(m_div);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("clock_out", 32'(cko), 32'(e_clk));
      chk("tick", 32'(tck), 32'(e_tick));
      chk("active", 32'(act), 32'(m_act));
      chk("cfg_ready", 32'(rdy), 32'(!m_pend));
      chk("cfg_error", 32'(err), 32'(e_err));
      chk("cur_divisor", 32'(cdiv), 32'(m_div));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic xfer_div(input int d);
      v  = 1'b1;
      dv = W'(d);
      step();
      v  = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      en = 1'b0;
      for (i = 0; i < 64 && m_act; i++) step();
      chk("wait_idle", 32'(m_act), 32'd0);
   endtask

   task automatic wait_pos(input int p);
      int i;
      bit hit;
      hit = 0;
      for (i = 0; i < 64; i++) begin
         if (m_act && m_q.size() == m_div - p) begin
            hit = 1;
            break;
         end
         step();
      end
      chk("wait_pos", 32'(hit), 32'd1);
   endtask

   task automatic run_div(input int d);
      wait_idle();
      xfer_div(d);
      en = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      v     = 1'b0;
      dv    = '0;
      steps(3);
      chk("rst_div", 32'(cdiv), 32'(DEF));
      chk("rst_clk", 32'(cko), 32'd0);
      rst_n = 1'b1;
      steps(2);
      en = 1'b1;
      steps(9);

      wait_idle();
      xfer_div(5);
      en = 1'b1;
      steps(16);

      run_div(8);
      wait_pos(2);
      xfer_div(3);
      chk("ready_low", 32'(rdy), 32'd0);
      steps(14);

      xfer_div(1);
      steps(3);
      xfer_div(0);
      steps(8);

      run_div(6);
      wait_pos(1);
      en = 1'b0;
      steps(10);
      en = 1'b1;
      wait_pos(2);
      en = 1'b0;
      steps(2);
      en = 1'b1;
      steps(12);

      run_div(10);
      steps(3);
      xfer_div(4);
      steps(2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_mid_div", 32'(cdiv), 32'(DEF));
      chk("rst_mid_rdy", 32'(rdy), 32'd1);
      chk("rst_mid_clk", 32'(cko), 32'd0);
      steps(6);

      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 24) == 0) en = ~en;
         v  = ($urandom_range(0, 5) == 0);
         dv = W'($urandom_range(0, 11));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
